// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin owner of a 3-to-8 select,
// bounded hold per grant, forced all-high gap after each grant.
module decoder_rr_arbiter #(
  parameter int HOLD_MAX    = 16,
  parameter int DEAD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [2:0] addr,
  output logic [7:0] grant_n,
  output logic       valid
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);
  localparam logic [DW-1:0] DMAX = DW'(DEAD_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

  state_e        state_q;
  logic [2:0]    ptr_q;
  logic [2:0]    addr_q;
  logic [7:0]    grant_n_q;
  logic          valid_q;
  logic [HW-1:0] hold_q;
  logic [DW-1:0] gap_q;

  logic [2:0] win_d;
  logic       hit_d;
  logic       rel_d;

  always_comb begin
    win_d = ptr_q;
    hit_d = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!hit_d && req[ptr_q + 3'(k)]) begin
        hit_d = 1'b1;
        win_d = ptr_q + 3'(k);
      end
    end
  end

  assign rel_d = !req[addr_q] || !en
              || (hold_q == HMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      addr_q    <= 3'd0;
      grant_n_q <= 8'hFF;
      valid_q   <= 1'b0;
      hold_q    <= '0;
      gap_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en && hit_d) begin
            addr_q    <= win_d;
            grant_n_q <= ~(8'b1 << win_d);
            valid_q   <= 1'b1;
            hold_q    <= HW'(1);
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          if (rel_d) begin
            valid_q   <= 1'b0;
            grant_n_q <= 8'hFF;
            ptr_q     <= addr_q + 3'd1;
            gap_q     <= DW'(1);
            state_q   <= GAP;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        GAP: begin
          if (gap_q == DMAX) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + DW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr    = addr_q;
  assign grant_n = grant_n_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter: directed vectors, expected
// outputs queued per cycle and checked by a monitor.
module tb_decoder_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [2:0] addr;
  logic [7:0] grant_n;
  logic       valid;

  typedef struct {
    int         id;
    logic [7:0] gn;
    logic [2:0] a;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   stepn  = 0;

  decoder_rr_arbiter #(
    .HOLD_MAX   (4),
    .DEAD_CYCLES(1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .req    (req),
    .addr   (addr),
    .grant_n(grant_n),
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // n cycles: drive inputs for the cycle and queue
  // the outputs expected during that same cycle
  task automatic step(
    input int         n,
    input logic       r,
    input logic       e,
    input logic [7:0] q,
    input logic [7:0] gn,
    input logic [2:0] a,
    input logic       v
  );
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = r;
      en    = e;
      req   = q;
      x.id  = stepn;
      x.gn  = gn;
      x.a   = a;
      x.v   = v;
      sb.push_back(x);
      stepn++;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if (grant_n !== x.gn || addr !== x.a
          || valid !== x.v) begin
        $display(
          "FAIL cyc%0d: got gn=%h addr=%0d v=%b, want gn=%h addr=%0d v=%b",
          x.id, grant_n, addr, valid, x.gn, x.a, x.v);
      end else begin
        passed++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    // reset with all requesting, then first grant to 0
    step(2, 0, 1, 8'hFF, 8'hFF, 3'd0, 0);
    step(1, 1, 1, 8'hFF, 8'hFF, 3'd0, 0);
    step(1, 1, 1, 8'h00, 8'hFE, 3'd0, 1);
    step(2, 1, 1, 8'h00, 8'hFF, 3'd0, 0);
    // single request to 5, three cycles
    step(1, 1, 1, 8'h20, 8'hFF, 3'd0, 0);
    step(2, 1, 1, 8'h20, 8'hDF, 3'd5, 1);
    step(1, 1, 1, 8'h00, 8'hDF, 3'd5, 1);
    step(2, 1, 1, 8'h00, 8'hFF, 3'd5, 0);
    // reset then fairness 0,7,0,7 with timeout 4
    step(1, 0, 1, 8'h00, 8'hFF, 3'd5, 0);
    step(1, 1, 1, 8'h81, 8'hFF, 3'd0, 0);
    step(4, 1, 1, 8'h81, 8'hFE, 3'd0, 1);
    step(2, 1, 1, 8'h81, 8'hFF, 3'd0, 0);
    step(4, 1, 1, 8'h81, 8'h7F, 3'd7, 1);
    step(2, 1, 1, 8'h81, 8'hFF, 3'd7, 0);
    step(4, 1, 1, 8'h81, 8'hFE, 3'd0, 1);
    step(2, 1, 1, 8'h81, 8'hFF, 3'd0, 0);
    step(4, 1, 1, 8'h81, 8'h7F, 3'd7, 1);
    // wrap after 7: 0 then 1
    step(2, 1, 1, 8'h03, 8'hFF, 3'd7, 0);
    step(1, 1, 1, 8'h02, 8'hFE, 3'd0, 1);
    step(2, 1, 1, 8'h02, 8'hFF, 3'd0, 0);
    step(1, 1, 1, 8'h00, 8'hFD, 3'd1, 1);
    step(2, 1, 1, 8'h00, 8'hFF, 3'd1, 0);
    // single owner timeout
    step(1, 1, 1, 8'h04, 8'hFF, 3'd1, 0);
    step(4, 1, 1, 8'h04, 8'hFB, 3'd2, 1);
    step(2, 1, 1, 8'h04, 8'hFF, 3'd2, 0);
    step(4, 1, 1, 8'h04, 8'hFB, 3'd2, 1);
    step(1, 1, 1, 8'h04, 8'hFF, 3'd2, 0);
    step(2, 1, 1, 8'h00, 8'hFF, 3'd2, 0);
    // en drop mid-grant, en low in idle
    step(1, 1, 1, 8'h08, 8'hFF, 3'd2, 0);
    step(1, 1, 1, 8'h08, 8'hF7, 3'd3, 1);
    step(1, 1, 0, 8'h08, 8'hF7, 3'd3, 1);
    step(3, 1, 0, 8'h08, 8'hFF, 3'd3, 0);
    // regrant then reset mid-grant
    step(1, 1, 1, 8'h08, 8'hFF, 3'd3, 0);
    step(1, 1, 1, 8'h08, 8'hF7, 3'd3, 1);
    step(1, 0, 1, 8'h08, 8'hF7, 3'd3, 1);
    step(2, 1, 1, 8'h00, 8'hFF, 3'd0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d left, want 0",
               sb.size());
    end else begin
      passed++;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
